// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives the data bus, waits for ack or
// timeout, and registers the MEM/WB bundle.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] store_data_in,
  input  logic [3:0]  reg_dst_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        reg_wr_in,
  input  logic        wb_sel_in,
  input  logic        call_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_pc_plus4,
  output logic [3:0]  wb_reg_dst,
  output logic        wb_reg_wr,
  output logic        wb_sel_out,
  output logic        wb_call,
  output logic [1:0]  wb_exc
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [31:0] pc4;
    logic [3:0]  dst;
    logic        wr;
    logic        sel;
    logic        call;
    logic [1:0]  exc;
  } wb_t;

  state_t      state, state_nx;
  logic [CW-1:0] cnt;
  logic        kill;
  logic [31:0] cap_addr, cap_wdata, cap_pc4;
  logic [3:0]  cap_dst;
  logic        cap_we, cap_wr, cap_sel, cap_call;
  wb_t         wb, wb_nx;

  logic access, aligned, go, tmo;
  logic req, we, stall, load, cap_en, done;
  logic [31:0] addr, wdata;

  assign access  = mem_rd_in | mem_wr_in;
  assign aligned = alu_out_in[1:0] == 2'b00;
  assign go      = access & aligned;
  assign tmo     = (state == BUSY) & !dmem_ack
                 & (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    we       = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    stall    = 1'b0;
    load     = 1'b0;
    cap_en   = 1'b0;
    done     = 1'b0;
    wb_nx    = '0;
    unique case (state)
      IDLE: begin
        wb_nx.alu  = alu_out_in;
        wb_nx.pc4  = pc_plus4_in;
        wb_nx.dst  = reg_dst_in;
        wb_nx.wr   = reg_wr_in;
        wb_nx.sel  = wb_sel_in;
        wb_nx.call = call_in;
        if (flush) begin
          load  = 1'b1;
          wb_nx = '0;
        end else if (go) begin
          req   = 1'b1;
          we    = mem_wr_in;
          addr  = alu_out_in;
          wdata = store_data_in;
          if (dmem_ack) begin
            load = 1'b1;
            if (!mem_wr_in) wb_nx.mdata = dmem_rdata;
          end else begin
            stall    = 1'b1;
            cap_en   = 1'b1;
            state_nx = BUSY;
          end
        end else begin
          load = 1'b1;
          if (access) begin
            wb_nx.exc = 2'b01;
            wb_nx.wr  = 1'b0;
          end
        end
      end
      BUSY: begin
        req   = 1'b1;
        we    = cap_we;
        addr  = cap_addr;
        wdata = cap_wdata;
        if (dmem_ack || tmo) begin
          load       = 1'b1;
          done       = 1'b1;
          state_nx   = IDLE;
          wb_nx.alu  = cap_addr;
          wb_nx.pc4  = cap_pc4;
          wb_nx.dst  = cap_dst;
          wb_nx.wr   = cap_wr;
          wb_nx.sel  = cap_sel;
          wb_nx.call = cap_call;
          if (dmem_ack && !cap_we) wb_nx.mdata = dmem_rdata;
          if (tmo) begin
            wb_nx.exc = 2'b10;
            wb_nx.wr  = 1'b0;
          end
          if (kill || flush) wb_nx = '0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dmem_req   = req & !rst;
  assign dmem_we    = we & !rst;
  assign dmem_addr  = addr;
  assign dmem_wdata = wdata;
  assign mem_stall  = stall & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      kill      <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_pc4   <= '0;
      cap_dst   <= '0;
      cap_we    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_sel   <= 1'b0;
      cap_call  <= 1'b0;
      wb        <= '0;
    end else begin
      state <= state_nx;
      if (cap_en) begin
        cnt       <= '0;
        cap_addr  <= alu_out_in;
        cap_wdata <= store_data_in;
        cap_we    <= mem_wr_in;
        cap_pc4   <= pc_plus4_in;
        cap_dst   <= reg_dst_in;
        cap_wr    <= reg_wr_in;
        cap_sel   <= wb_sel_in;
        cap_call  <= call_in;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      // kill outlives the flush pulse until the bus transaction ends
      if (done) kill <= 1'b0;
      else if (state == BUSY && flush) kill <= 1'b1;
      if (load) wb <= wb_nx;
    end
  end

  assign wb_alu_out  = wb.alu;
  assign wb_mem_data = wb.mdata;
  assign wb_pc_plus4 = wb.pc4;
  assign wb_reg_dst  = wb.dst;
  assign wb_reg_wr   = wb.wr;
  assign wb_sel_out  = wb.sel;
  assign wb_call     = wb.call;
  assign wb_exc      = wb.exc;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum cycles a data-memory access may wait for dmem_ack.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  kill the instruction currently in this stage.
REQ-005 alu_out_in  in  32  ALU result, also the memory address.
REQ-006 store_data_in  in  32  store write data.
REQ-007 reg_dst_in  in  4  destination register.
REQ-008 pc_plus4_in  in  32  return address.
REQ-009 reg_wr_in, wb_sel_in, call_in  in  1 each  write-back controls.
REQ-010 mem_rd_in, mem_wr_in  in  1 each  load / store request.
REQ-011 dmem_req  out  1  memory request.
REQ-012 dmem_we  out  1  1 = write.
REQ-013 dmem_addr, dmem_wdata  out  32 each  request address and write data.
REQ-014 dmem_ack  in  1  access complete.
REQ-015 dmem_rdata  in  32  load data, valid with dmem_ack.
REQ-016 mem_stall  out  1  freeze all upstream pipeline registers.
REQ-017 wb_alu_out, wb_mem_data, wb_pc_plus4  out  32 each  registered MEM/WB data.
REQ-018 wb_reg_dst  out  4; wb_reg_wr, wb_sel_out, wb_call  out  1 each  registered MEM/WB controls.
REQ-019 wb_exc  out  2  registered exception code: 00 none, 01 misaligned, 10 timeout.

Function
REQ-020 Access = mem_rd_in | mem_wr_in; when both are set, the block SHALL perform a write.
REQ-021 Misaligned access (alu_out_in[1:0] != 0) SHALL issue no request, complete in 1 cycle, and load wb_exc=01 and wb_reg_wr=0.
REQ-022 FSM states SHALL be IDLE and BUSY.
REQ-023 IDLE with an aligned access: dmem_req=1 combinationally, driven from alu_out_in and store_data_in; dmem_we=mem_wr_in.
REQ-024 IDLE with an aligned access and dmem_ack=1 at the edge: zero-wait completion, MEM/WB loads, and the FSM stays in IDLE.
REQ-025 IDLE with an aligned access and dmem_ack=0 at the edge: capture address, wdata, we and all pass-through fields, clear the wait counter, and go to BUSY.
REQ-026 BUSY: dmem_req=1, with address, data and we driven from captured registers and held stable until completion.
REQ-027 BUSY: the wait counter SHALL increment once per cycle.
REQ-028 BUSY to IDLE on dmem_ack=1, with MEM/WB loaded.
REQ-029 BUSY with the counter reaching TIMEOUT-1 and no ack: drop dmem_req next cycle, return to IDLE, and load MEM/WB with wb_exc=10 and wb_reg_wr=0.
REQ-030 A dmem_ack arriving in IDLE with no access SHALL be ignored.
REQ-031 mem_stall = (IDLE & aligned access & !dmem_ack) | (BUSY & !dmem_ack & !timeout), combinational.
REQ-032 Non-memory instruction: mem_stall=0 and MEM/WB loads on the next edge (1-cycle latency).
REQ-033 MEM/WB load fields:
- wb_mem_data = dmem_rdata for a completed load, else 0.
- All other fields pass through from the inputs, or from captured values when completing from BUSY.
REQ-034 MEM/WB SHALL hold its value on any edge where mem_stall=1.
REQ-035 flush in IDLE SHALL zero all MEM/WB outputs on the next edge and issue no request.
REQ-036 flush in BUSY SHALL set a kill flag while the bus transaction continues to ack or timeout; on completion MEM/WB loads all zeros, and the kill flag clears.
REQ-037 flush SHALL have priority over normal MEM/WB loading; mem_stall SHALL still reflect an outstanding access.

Reset
REQ-038 While rst=1, dmem_req, dmem_we and mem_stall SHALL be 0.
REQ-039 On a rst edge: FSM to IDLE, counter, kill flag, captured registers and all wb_* outputs to 0.
REQ-040 rst in BUSY SHALL abandon the access with no MEM/WB update other than clearing.

Verification
REQ-041 Bench scenarios:
- Non-memory instruction, alu_out_in=0x1234, reg_wr_in=1 -> next edge wb_alu_out=0x1234, wb_reg_wr=1, mem_stall never 1.
- Load at 0x100, dmem_ack tied high, dmem_rdata=0xDEADBEEF -> dmem_req for 1 cycle, no stall, wb_mem_data=0xDEADBEEF next edge.
- Store at 0x200, data 0xA5A5A5A5, ack after 3 cycles -> mem_stall=1 for 3 cycles, dmem_addr/wdata stable, dmem_we=1, wb_mem_data=0.
- Load at 0x102 -> dmem_req never 1, wb_exc=01, wb_reg_wr=0.
- Load with no ack, TIMEOUT=16 -> stall for 16 cycles, then dmem_req=0, wb_exc=10, wb_reg_wr=0.
- Load pending 2 cycles, flush pulse, ack on cycle 4 -> all wb_* = 0; rst during BUSY -> IDLE, dmem_req=0 while rst=1.
